icache_axi_rd_bridge: RTL and testbench

Read-side bus bridge that serves instruction-cache line refills. It accepts one line request at a time from the instruction cache's miss port (`icache_rd_req`/`icache_rd_addr`), issues a single 4-beat INCR burst on the AXI read address channel, and assembles the returned beats into a 128-bit line. It hands the line back with a one-cycle `icache_ret_valid` pulse. It sits between the ICache and the CPU's AXI master interface.

---
 rtl/icache_axi_rd_bridge.sv | 158 +++++++++++++++
 tb/tb_icache_axi_rd_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_rd_bridge.sv
// ---------------------------------------------------------------------------
// icache_axi_rd_bridge
//
// Purpose:
//   This bridge refills lines for the instruction cache over the AXI read
//   channels. It takes one line request at a time from the ICache miss port.
//   For each request it issues a single INCR burst of LINE_WORDS beats. The
//   returned beats are assembled into one line, and the line is handed back
//   to the cache with a one-cycle valid pulse.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   icache_rd_req     line refill request (held until accepted)
//   icache_rd_addr    line address; the line-offset bits are ignored
//   icache_rd_rdy     accept strobe (high only in IDLE, low during reset)
//   icache_ret_valid  one-cycle pulse; the assembled line is valid
//   icache_ret_data   assembled line register; word n at [32n+31:32n]
//   arid/araddr/arlen/arsize/arburst/arvalid/arready
//                     AXI read address channel (master side)
//   rid/rdata/rresp/rlast/rvalid/rready
//                     AXI read data channel (master side)
// ---------------------------------------------------------------------------
module icache_axi_rd_bridge #(
   parameter int         LINE_WORDS = 4,
   parameter int         DATA_WIDTH = 32,
   parameter logic [3:0] AXI_ID     = 4'd0
) (
   input  logic                             clk,
   input  logic                             reset,

   input  logic                             icache_rd_req,
   input  logic [31:0]                      icache_rd_addr,
   output logic                             icache_rd_rdy,
   output logic                             icache_ret_valid,
   output logic [LINE_WORDS*DATA_WIDTH-1:0] icache_ret_data,

   output logic [3:0]                       arid,
   output logic [31:0]                      araddr,
   output logic [7:0]                       arlen,
   output logic [2:0]                       arsize,
   output logic [1:0]                       arburst,
   output logic                             arvalid,
   input  logic                             arready,

   input  logic [3:0]                       rid,
   input  logic [DATA_WIDTH-1:0]            rdata,
   input  logic [1:0]                       rresp,
   input  logic                             rlast,
   input  logic                             rvalid,
   output logic                             rready
);

   localparam int LINE_W = LINE_WORDS * DATA_WIDTH;
   // Byte-offset bits inside one line. They are forced to zero on araddr.
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam int CNT_W  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AR   = 2'd1,
      S_R    = 2'd2,
      S_RET  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        addr_q,  addr_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [LINE_W-1:0]  line_q,  line_d;

   // The bridge keeps only one burst outstanding, so it never needs rid.
   // It also ignores rresp and the line-offset address bits.
   logic unused_ok;
   assign unused_ok = ^{rid, rresp, icache_rd_addr[OFF_W-1:0]};

   // ------------------------------------------------------------------
   // Next-state and datapath update
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      line_d  = line_q;

      unique case (state_q)
         S_IDLE: begin
            if (icache_rd_req) begin
               addr_d  = {icache_rd_addr[31:OFF_W], {OFF_W{1'b0}}};
               cnt_d   = '0;
               line_d  = '0;
               state_d = S_AR;
            end
         end

         S_AR: begin
            if (arready) begin
               state_d = S_R;
            end
         end

         S_R: begin
            // Only rlast ends the burst. If rlast comes early, the words
            // not yet written stay zero. If it comes late, the counter wraps
            // (LINE_WORDS is a power of two) and writing restarts at word 0.
            if (rvalid) begin
               line_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = rdata;
               cnt_d = cnt_q + 1'b1;
               if (rlast) begin
                  state_d = S_RET;
               end
            end
         end

         S_RET: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // The state register is still in IDLE while reset is high, so the
   // accept strobe is gated with reset. This keeps a request from being
   // accepted during reset.
   assign icache_rd_rdy    = (state_q == S_IDLE) && !reset;
   assign icache_ret_valid = (state_q == S_RET);
   assign icache_ret_data  = line_q;

   assign arid    = AXI_ID;
   assign araddr  = addr_q;
   assign arlen   = 8'(LINE_WORDS - 1);
   assign arsize  = 3'($clog2(DATA_WIDTH / 8));
   assign arburst = 2'b01;
   assign arvalid = (state_q == S_AR);
   assign rready  = (state_q == S_R);

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// ---------------------------------------------------------------------------
// tb_icache_axi_rd_bridge
//
// Bench for icache_axi_rd_bridge. The main process plays two roles: it acts
// as the ICache requester and as a simple AXI slave. Each time a request is
// accepted, it pushes the expected line onto a scoreboard queue. A monitor
// pops that line and compares it on every icache_ret_valid pulse.
// ---------------------------------------------------------------------------
module tb_icache_axi_rd_bridge;

   logic          clk = 1'b0;
   logic          reset;
   logic          icache_rd_req;
   logic [31:0]   icache_rd_addr;
   logic          icache_rd_rdy;
   logic          icache_ret_valid;
   logic [127:0]  icache_ret_data;
   logic [3:0]    arid;
   logic [31:0]   araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arvalid;
   logic          arready;
   logic [3:0]    rid;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic          rvalid;
   logic          rready;

   icache_axi_rd_bridge #(
      .LINE_WORDS (4),
      .DATA_WIDTH (32),
      .AXI_ID     (4'd0)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .icache_rd_req    (icache_rd_req),
      .icache_rd_addr   (icache_rd_addr),
      .icache_rd_rdy    (icache_rd_rdy),
      .icache_ret_valid (icache_ret_valid),
      .icache_ret_data  (icache_ret_data),
      .arid             (arid),
      .araddr           (araddr),
      .arlen            (arlen),
      .arsize           (arsize),
      .arburst          (arburst),
      .arvalid          (arvalid),
      .arready          (arready),
      .rid              (rid),
      .rdata            (rdata),
      .rresp            (rresp),
      .rlast            (rlast),
      .rvalid           (rvalid),
      .rready           (rready)
   );

   always #5 clk = ~clk;

   int            n_chk = 0;
   int            n_err = 0;
   int            n_ret = 0;
   int            n_ret_exp = 0;
   logic [127:0]  sb_q [$];
   logic [31:0]   bw [8];

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, req, $time);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: sample away from the active edge.
   always @(negedge clk) begin
      if (icache_ret_valid) begin
         n_ret++;
         if (sb_q.size() == 0) begin
            chk("ret_unexpected", 128'(1), 128'(0));
         end else begin
            chk("ret_data_sb", icache_ret_data, sb_q.pop_front());
         end
      end
   end

   // One complete refill: accept, AR with ar_dly stall cycles, then nb beats
   // with gap idle cycles between beats. rlast is on the last beat. When
   // hold_req is set, the request stays high with next_addr for a follow-up.
   task automatic refill(input logic [31:0] addr, input int nb, input int ar_dly,
                         input int gap, input bit hold_req, input logic [31:0] next_addr);
      logic [127:0] exp_line;
      logic [31:0]  exp_addr;
      int           guard;
      icache_rd_req  = 1'b1;
      icache_rd_addr = addr;
      guard = 0;
      while (!icache_rd_rdy && guard < 50) begin
         step();
         guard++;
      end
      chk("rdy_before_accept", 128'(icache_rd_rdy), 128'(1));
      exp_line = '0;
      for (int i = 0; i < nb; i++) exp_line[(i % 4)*32 +: 32] = bw[i];
      exp_addr = {addr[31:4], 4'h0};
      sb_q.push_back(exp_line);
      n_ret_exp++;
      step();
      if (hold_req) begin
         icache_rd_addr = next_addr;
      end else begin
         icache_rd_req  = 1'b0;
         icache_rd_addr = $urandom;
      end
      // Cycle T+1: the address channel should be up.
      chk("arvalid_T1", 128'(arvalid), 128'(1));
      chk("araddr", 128'(araddr), 128'(exp_addr));
      chk("ar_fields", 128'({arid, arlen, arsize, arburst}), 128'({4'd0, 8'd3, 3'd2, 2'd1}));
      chk("rdy_in_ar", 128'(icache_rd_rdy), 128'(0));
      chk("line_cleared", icache_ret_data, 128'(0));
      for (int k = 0; k < ar_dly; k++) begin
         step();
         chk("arvalid_stall", 128'(arvalid), 128'(1));
         chk("araddr_stall", 128'(araddr), 128'(exp_addr));
         chk("rready_in_ar", 128'(rready), 128'(0));
      end
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk("arvalid_drop", 128'(arvalid), 128'(0));
      chk("rready_A1", 128'(rready), 128'(1));
      chk("rdy_in_r", 128'(icache_rd_rdy), 128'(0));
      for (int i = 0; i < nb; i++) begin
         if (i > 0) begin
            for (int g = 0; g < gap; g++) begin
               step();
               chk("rready_gap", 128'(rready), 128'(1));
               chk("ret_valid_gap", 128'(icache_ret_valid), 128'(0));
            end
         end
         rvalid = 1'b1;
         rdata  = bw[i];
         rlast  = (i == nb - 1);
         rid    = 4'($urandom);
         rresp  = 2'($urandom);
         step();
         rvalid = 1'b0;
         rlast  = 1'b0;
         rdata  = $urandom;
      end
      // Cycle L+1: return pulse with the complete line.
      chk("ret_valid_L1", 128'(icache_ret_valid), 128'(1));
      chk("ret_data_L1", icache_ret_data, exp_line);
      chk("rdy_in_ret", 128'(icache_rd_rdy), 128'(0));
      chk("rready_in_ret", 128'(rready), 128'(0));
      step();
      chk("ret_valid_one_cycle", 128'(icache_ret_valid), 128'(0));
      chk("rdy_idle", 128'(icache_rd_rdy), 128'(1));
      chk("ret_data_held", icache_ret_data, exp_line);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset          = 1'b1;
      icache_rd_req  = 1'b0;
      icache_rd_addr = '0;
      arready        = 1'b0;
      rid            = '0;
      rdata          = '0;
      rresp          = '0;
      rlast          = 1'b0;
      rvalid         = 1'b0;

      repeat (3) step();
      chk("rst_rdy", 128'(icache_rd_rdy), 128'(0));
      chk("rst_ctrl", 128'({arvalid, rready, icache_ret_valid}), 128'(0));
      chk("rst_data", icache_ret_data, 128'(0));
      chk("rst_araddr", 128'(araddr), 128'(0));
      reset = 1'b0;
      #1;
      chk("rdy_after_rst", 128'(icache_rd_rdy), 128'(1));
      step();

      // Basic refill with minimum latency.
      bw[0] = 32'h11; bw[1] = 32'h22; bw[2] = 32'h33; bw[3] = 32'h44;
      refill(32'h1FC0_0008, 4, 0, 0, 1'b0, 32'h0);
      chk("basic_line", icache_ret_data, 128'h00000044_00000033_00000022_00000011);

      // Backpressure: AR stalled 5 cycles, 2-cycle gaps between beats.
      bw[0] = 32'hDEAD0001; bw[1] = 32'hDEAD0002; bw[2] = 32'hDEAD0003; bw[3] = 32'hDEAD0004;
      refill(32'h8000_123C, 4, 5, 2, 1'b0, 32'h0);

      // Request held high through the first refill with a new address.
      bw[0] = 32'hA0; bw[1] = 32'hA1; bw[2] = 32'hA2; bw[3] = 32'hA3;
      refill(32'h0000_2000, 4, 1, 1, 1'b1, 32'h0000_1230);
      bw[0] = 32'hB0; bw[1] = 32'hB1; bw[2] = 32'hB2; bw[3] = 32'hB3;
      refill(32'h0000_1230, 4, 0, 0, 1'b0, 32'h0);

      // Early rlast after two beats.
      bw[0] = 32'hA; bw[1] = 32'hB;
      refill(32'h0000_4440, 2, 0, 0, 1'b0, 32'h0);
      chk("early_line", icache_ret_data, 128'h00000000_00000000_0000000B_0000000A);

      // Late rlast: the fifth beat wraps onto word 0.
      bw[0] = 32'h1; bw[1] = 32'h2; bw[2] = 32'h3; bw[3] = 32'h4; bw[4] = 32'h5;
      refill(32'h0000_5550, 5, 0, 1, 1'b0, 32'h0);
      chk("wrap_line", icache_ret_data, 128'h00000004_00000003_00000002_00000005);

      // Reset after the second beat of a burst.
      icache_rd_req  = 1'b1;
      icache_rd_addr = 32'h4000_0020;
      #0;
      chk("rst_mid_rdy", 128'(icache_rd_rdy), 128'(1));
      step();
      icache_rd_req = 1'b0;
      arready = 1'b1;
      step();
      arready = 1'b0;
      chk("rst_mid_rready", 128'(rready), 128'(1));
      for (int i = 0; i < 2; i++) begin
         rvalid = 1'b1;
         rdata  = 32'hCC00 + i;
         step();
      end
      rvalid = 1'b0;
      reset  = 1'b1;
      step();
      chk("rst_mid_ctrl", 128'({arvalid, rready, icache_ret_valid}), 128'(0));
      chk("rst_mid_data", icache_ret_data, 128'(0));
      chk("rst_mid_araddr", 128'(araddr), 128'(0));
      chk("rst_mid_rdy", 128'(icache_rd_rdy), 128'(0));
      reset = 1'b0;
      step();
      chk("rst_mid_no_ret", 128'(icache_ret_valid), 128'(0));
      chk("rst_mid_idle", 128'(icache_rd_rdy), 128'(1));
      bw[0] = 32'h51; bw[1] = 32'h52; bw[2] = 32'h53; bw[3] = 32'h54;
      refill(32'h4000_0020, 4, 0, 0, 1'b0, 32'h0);

      // A few randomised refills.
      for (int n = 0; n < 4; n++) begin
         for (int i = 0; i < 4; i++) bw[i] = $urandom;
         refill($urandom, 4, int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0, 32'h0);
      end

      repeat (3) step();
      chk("ret_count", 128'(n_ret), 128'(n_ret_exp));
      chk("sb_empty", 128'(sb_q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
